// File: rtl/stopwatch_pkg.sv
// Shared constants and types for the stopwatch multiplexed 7-segment display.
// Segment codes are active-low, bit order g,f,e,d,c,b,a (bit6..bit0).
package stopwatch_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Digit index doubles as the anode bit position.
  localparam logic [1:0] DIG_SEC_ONES  = 2'd0;
  localparam logic [1:0] DIG_SEC_TENS  = 2'd1;
  localparam logic [1:0] DIG_MIN_ONES  = 2'd2;
  localparam logic [1:0] DIG_MIN_TENS  = 2'd3;
  localparam logic [1:0] DIG_SEPARATOR = DIG_MIN_ONES;

  localparam logic [5:0] RADIX = 6'd10;

  typedef enum logic [1:0] {
    IDLE,
    CONV_SEC,
    CONV_MIN,
    COMMIT
  } conv_state_t;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } bcd_frame_t;

  function automatic logic [3:0] frame_digit(input bcd_frame_t frame, input logic [1:0] idx);
    case (idx)
      DIG_SEC_ONES: return frame.sec_ones;
      DIG_SEC_TENS: return frame.sec_tens;
      DIG_MIN_ONES: return frame.min_ones;
      default:      return frame.min_tens;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low 7-segment decoder; codes 10..15 blank.
module seg7_decoder
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] segments
);

  always_comb begin
    // NOTE: the default arm assigns on every path, so no latch is inferred.
    case (bcd)
      4'd0:    segments = SEG_0;
      4'd1:    segments = SEG_1;
      4'd2:    segments = SEG_2;
      4'd3:    segments = SEG_3;
      4'd4:    segments = SEG_4;
      4'd5:    segments = SEG_5;
      4'd6:    segments = SEG_6;
      4'd7:    segments = SEG_7;
      4'd8:    segments = SEG_8;
      4'd9:    segments = SEG_9;
      default: segments = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stopwatch_display.sv
// Four-digit multiplexed MM:SS display: captures the counter once per frame,
// converts binary to BCD by repeated subtraction and swaps the whole frame at once.
module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  output logic [3:0] anodes,
  output logic [6:0] segments,
  output logic       dp
);

  localparam int unsigned         PRESC_W   = $clog2(REFRESH_DIV);
  localparam logic [PRESC_W-1:0]  PRESC_MAX = PRESC_W'(REFRESH_DIV - 1);

  logic [PRESC_W-1:0] presc;
  logic [1:0]         digit_idx;
  logic               frame_start;

  conv_state_t state;
  logic [5:0]  hold_min;
  logic [5:0]  hold_sec;
  logic [2:0]  tens;
  logic [3:0]  sec_tens;
  bcd_frame_t  shown;

  logic [3:0]  cur_digit;
  logic [6:0]  seg_next;

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      presc     <= '0;
      digit_idx <= DIG_SEC_ONES;
    end else if (presc == PRESC_MAX) begin
      presc     <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      presc     <= presc + PRESC_W'(1);
    end
  end

  assign frame_start = (presc == '0) && (digit_idx == DIG_SEC_ONES);

  // The holding registers double as the subtraction work registers; once a
  // field drops below 10 its low nibble is already the ones digit.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      hold_min <= '0;
      hold_sec <= '0;
      tens     <= '0;
      sec_tens <= '0;
      shown    <= '0;
    end else if (frame_start) begin
      hold_min <= minutes;
      hold_sec <= seconds;
      tens     <= '0;
      state    <= CONV_SEC;
    end else begin
      case (state)
        IDLE: state <= IDLE;
        CONV_SEC: begin
          if (hold_sec < RADIX) begin
            sec_tens <= {1'b0, tens};
            tens     <= '0;
            state    <= CONV_MIN;
          end else begin
            hold_sec <= hold_sec - RADIX;
            tens     <= tens + 3'd1;
          end
        end
        CONV_MIN: begin
          if (hold_min < RADIX) begin
            state <= COMMIT;
          end else begin
            hold_min <= hold_min - RADIX;
            tens     <= tens + 3'd1;
          end
        end
        COMMIT: begin
          shown <= '{min_tens: {1'b0, tens},
                     min_ones: hold_min[3:0],
                     sec_tens: sec_tens,
                     sec_ones: hold_sec[3:0]};
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cur_digit = frame_digit(shown, digit_idx);

  seg7_decoder u_seg7_decoder (
    .bcd      (cur_digit),
    .segments (seg_next)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      anodes   <= 4'b1111;
      segments <= SEG_BLANK;
      dp       <= 1'b1;
    end else begin
      anodes   <= ~(4'b0001 << digit_idx);
      segments <= seg_next;
      dp       <= (digit_idx != DIG_SEPARATOR);
    end
  end

endmodule

// File: tb/tb_stopwatch_display.sv
// Self-checking bench for stopwatch_display: directed scenarios plus random inputs,
// checked every cycle against a frame-level arithmetic model of the display.
module tb_stopwatch_display;

  localparam int DIV   = 16;
  localparam int FRAME = 4 * DIV;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [3:0] anodes;
  logic [6:0] segments;
  logic       dp;

  stopwatch_display #(.REFRESH_DIV(DIV)) dut (
    .clock    (clock),
    .reset    (reset),
    .minutes  (minutes),
    .seconds  (seconds),
    .anodes   (anodes),
    .segments (segments),
    .dp       (dp)
  );

  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;

  // Model state: s = cycles since the first non-reset cycle after the last reset.
  int s;
  bit rst_edge;
  int shown_min, shown_sec;
  int pend_min, pend_sec, pend_at;
  bit pend_valid;

  logic [6:0] seg_table [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

  function automatic logic [6:0] seg_of(input int d);
    return (d < 10) ? seg_table[d] : 7'b1111111;
  endfunction

  function automatic int digit_of(input int idx, input int m, input int sc);
    case (idx)
      0:       return sc % 10;
      1:       return sc / 10;
      2:       return m % 10;
      default: return m / 10;
    endcase
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, s);
    end
  endtask

  // Account for the coming rising edge using the inputs now applied, then
  // compare the registered outputs on the following falling edge.
  task automatic tick();
    int idx;
    logic [3:0] exp_an;
    if (reset) begin
      rst_edge   = 1'b1;
      s          = 0;
      shown_min  = 0;
      shown_sec  = 0;
      pend_valid = 1'b0;
    end else begin
      if (s % FRAME == 0) begin
        pend_min   = int'(minutes);
        pend_sec   = int'(seconds);
        pend_at    = s + 3 + pend_sec / 10 + pend_min / 10;
        pend_valid = 1'b1;
      end
      rst_edge = 1'b0;
      s++;
    end
    @(negedge clock);
    if (rst_edge) begin
      check("reset_anodes",   {3'b000, anodes},  7'b0001111);
      check("reset_segments", segments,          7'b1111111);
      check("reset_dp",       {6'b0, dp},        7'd1);
    end else begin
      if (pend_valid && pend_at < s - 1) begin
        shown_min  = pend_min;
        shown_sec  = pend_sec;
        pend_valid = 1'b0;
      end
      idx    = ((s - 1) / DIV) % 4;
      exp_an = ~(4'b0001 << idx);
      check("anodes",    {3'b000, anodes}, {3'b000, exp_an});
      check("one_low",   7'($countones(~anodes)), 7'd1);
      check("segments",  segments, seg_of(digit_of(idx, shown_min, shown_sec)));
      check("dp",        {6'b0, dp}, (idx == 2) ? 7'd0 : 7'd1);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    run(n);
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    minutes = '0;
    seconds = '0;
    run(3);

    // 12:34, then bump seconds while the minutes-ones digit is lit.
    minutes = 6'd12;
    seconds = 6'd34;
    reset   = 1'b0;
    run(2 * FRAME + 2 * DIV);
    seconds = 6'd35;
    run(2 * FRAME);

    // Worst-case conversion length.
    apply_reset(2);
    minutes = 6'd63;
    seconds = 6'd63;
    run(2 * FRAME);

    // No leading-zero blanking.
    apply_reset(2);
    minutes = 6'd0;
    seconds = 6'd5;
    run(2 * FRAME);

    // Reset during the minutes conversion of a 59:59 capture.
    apply_reset(2);
    minutes = 6'd59;
    seconds = 6'd59;
    run(9);
    apply_reset(2);
    minutes = 6'd7;
    seconds = 6'd8;
    run(2 * FRAME);

    // Random inputs changing every cycle, with a few random reset pulses.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < int'($urandom_range(200, 20)); i++) begin
        minutes = 6'($urandom_range(63, 0));
        seconds = 6'($urandom_range(63, 0));
        tick();
      end
      apply_reset(1);
    end
    for (int i = 0; i < 8 * FRAME; i++) begin
      minutes = 6'($urandom_range(63, 0));
      seconds = 6'($urandom_range(63, 0));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/stopwatch_display.md
STOPWATCH_DISPLAY -- requirements
Module: stopwatch_display

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: clock cycles each digit stays enabled; legal range 16..2^20.
REQ-002 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 minutes  input  6  binary minutes from the stopwatch counter, 0..63.
REQ-005 seconds  input  6  binary seconds from the stopwatch counter, 0..63.
REQ-006 anodes  output  4  active-low digit enables: [0] sec ones, [1] sec tens, [2] min ones, [3] min tens.
REQ-007 segments  output  7  active-low segments, bit order g,f,e,d,c,b,a (bit6..bit0).
REQ-008 dp  output  1  active-low decimal point.

Function
REQ-009 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; on each wrap the 2-bit digit index SHALL advance 0->1->2->3->0.
REQ-010 Frame start SHALL be the cycle where prescaler==0 and index==0, including the first cycle after reset deasserts.
REQ-011 At frame start, minutes and seconds SHALL be captured into holding registers; inputs at other times SHALL be ignored.
REQ-012 Converter FSM states IDLE, CONV_SEC, CONV_MIN, COMMIT: IDLE->CONV_SEC on capture; CONV_SEC->CONV_MIN when remainder<10; CONV_MIN->COMMIT when remainder<10; COMMIT->IDLE after one cycle.
REQ-013 Conversion SHALL be by repeated subtraction of 10, one subtraction per cycle; tens = subtraction count (0..6), ones = final remainder (0..9).
REQ-014 Worst-case capture-to-COMMIT SHALL be 15 cycles (63 and 63); REFRESH_DIV>=16 guarantees completion inside digit 0's slot.
REQ-015 In COMMIT, all four displayed BCD digits SHALL update in the same cycle; no mixed old/new frame is ever displayed.
REQ-016 Inputs >59 SHALL be converted arithmetically and not clamped, e.g. 61 -> "61".
REQ-017 anodes, segments and dp SHALL be registered: values in cycle n+1 reflect index and displayed digits in cycle n.
REQ-018 Exactly one anode bit SHALL be low at any time outside reset.
REQ-019 Segment codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; codes 10..15 SHALL blank (1111111).
REQ-020 dp SHALL be low only while index==2, marking the minutes/seconds separator; otherwise high.
REQ-021 No leading-zero blanking: 0 min 5 s SHALL display "0005".

Reset
REQ-022 While reset is high: prescaler=0, index=0, FSM=IDLE, holding and displayed digits=0, anodes=1111, segments=1111111, dp=1.
REQ-023 Reset asserted mid-conversion SHALL abort it with no COMMIT; the display SHALL restart from "0000" with a fresh capture.
REQ-024 First cycle after reset: frame start and capture; first registered output (anodes=1110, segments=1000000) one cycle later.

Structure
REQ-025 Package stopwatch_pkg SHALL hold the segment-code constants, the digit-index constants and the FSM state typedef.
REQ-026 Sub-module seg7_decoder SHALL implement REQ-019: combinational 4-bit BCD in, 7-bit active-low segments out.

Verification
REQ-027 REFRESH_DIV=16; reset, minutes=12, seconds=34 -> anodes cycle 1110,1101,1011,0111 every 16 cycles; segments 0011001,0110000,0100100,1111001; dp low only with anodes=1011.
REQ-028 minutes=63, seconds=63 -> COMMIT exactly 15 cycles after capture; display "6363".
REQ-029 Change seconds 34->35 while index=2 -> display unchanged until next frame start, then seconds ones shows 0010010.
REQ-030 Pulse reset during CONV_MIN after a 59:59 capture -> no COMMIT; display stays "0000" until the post-reset capture completes.
REQ-031 Sample every cycle after reset -> exactly one anode low; anode changes occur only one cycle after prescaler wrap.
REQ-032 minutes=0, seconds=5 -> digits show 1000000,1000000,1000000,0010010 (min tens to sec ones).
